matrix_stream_loader: RTL and testbench

Upstream feeder for the combinational 4x4 matrix multiplier. It accepts matrix elements one per beat over a valid/ready stream: A in row-major order, then B in row-major order. It holds both operands in registers and presents them as flattened buses with a valid/ready handshake. The multiplier result is valid while `out_valid` is high, because the multiplier reads these held registers combinationally.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matrix_stream_loader.sv | 102 ++++++++++
 tb/tb_matrix_stream_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the 4x4 matrix multiplier datapath: default sizes,
// loader FSM states and the flat-bus element offset used for packing/unpacking.
package matmul_pkg;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Bit offset of element [i][j] in a row-major flattened N x N bus.
  function automatic int flat_off(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Streams A then B (row-major, one element per beat) into held registers and
// presents them as a flat operand pair for the combinational multiplier.
module matrix_stream_loader
  import matmul_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N*N*W-1:0] a_flat,
  output logic [N*N*W-1:0] b_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       pair_cnt
);

  localparam int NE = N * N;
  localparam int IW = $clog2(NE);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NE*W-1:0] a_q, a_d;
  logic [NE*W-1:0] b_q, b_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            beat;
  logic            last_beat;

  // Handshake outputs come from registered state only.
  assign in_ready  = (state_q != PRESENT);
  assign out_valid = (state_q == PRESENT);
  assign a_flat    = a_q;
  assign b_flat    = b_q;
  assign pair_cnt  = cnt_q;

  assign beat      = in_valid && in_ready;
  assign last_beat = (idx_q == IW'(NE - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_A: begin
        if (beat) begin
          for (int k = 0; k < NE; k++) begin
            if (idx_q == IW'(k)) a_d[flat_off(k / N, k % N, N, W) +: W] = in_data;
          end
          idx_d = last_beat ? '0 : idx_q + IW'(1);
          if (last_beat) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (beat) begin
          for (int k = 0; k < NE; k++) begin
            if (idx_q == IW'(k)) b_d[flat_off(k / N, k % N, N, W) +: W] = in_data;
          end
          idx_d = last_beat ? '0 : idx_q + IW'(1);
          if (last_beat) state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
    // Abort wins over any beat or delivery this cycle and leaves storage untouched.
    if (clear) begin
      state_d = LOAD_A;
      idx_d   = '0;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: expected operand pairs are queued
// as they are streamed in and compared when the loader presents them.
module tb_matrix_stream_loader;

  logic         clk = 1'b0;
  logic         reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   in_data, pair_cnt;
  logic [127:0] a_flat, b_flat;

  typedef struct packed {
    logic [127:0] a;
    logic [127:0] b;
  } pair_t;

  pair_t        sb[$];
  pair_t        last_p, p;
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           t0;
  logic [7:0]   exp_cnt;
  logic [255:0] c_res, a_ext;
  logic [15:0]  sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_stream_loader #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .pair_cnt(pair_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_elem(input logic [7:0] d, input bit gappy);
    int guard;
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_beats(input logic [127:0] a, input logic [127:0] b,
                            input int first, input int last, input bit gappy);
    for (int k = first; k <= last; k++) begin
      if (k < 16) drive_elem(a[k*8 +: 8], gappy);
      else        drive_elem(b[(k-16)*8 +: 8], gappy);
    end
  endtask

  task automatic wait_present();
    int guard;
    guard = 0;
    while (!out_valid && guard < 300) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
    end else if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      last_p = sb.pop_front();
      chk("a_flat", a_flat, last_p.a);
      chk("b_flat", b_flat, last_p.b);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("turn_out_valid", out_valid, 0);
    chk("turn_in_ready", in_ready, 1);
    chk("pair_cnt", pair_cnt, exp_cnt);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    exp_cnt = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a_flat", a_flat, 0);
    chk("rst_b_flat", b_flat, 0);
    chk("rst_pair_cnt", pair_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic load: A = 1..16, B = identity
    for (int k = 0; k < 16; k++) p.a[k*8 +: 8] = 8'(k + 1);
    p.b = '0;
    for (int i = 0; i < 4; i++) p.b[(i*5)*8 +: 8] = 8'd1;
    sb.push_back(p);
    t0 = cyc;
    load_beats(p.a, p.b, 0, 30, 1'b0);
    chk("out_valid_early", out_valid, 0);
    load_beats(p.a, p.b, 31, 31, 1'b0);
    chk("latency", 256'(cyc - t0), 32);
    wait_present();
    chk("a_first_elem", a_flat[7:0], 8'd1);
    chk("a_last_elem", a_flat[127:120], 8'd16);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        sum = '0;
        for (int k = 0; k < 4; k++)
          sum = sum + 16'(a_flat[(i*4+k)*8 +: 8]) * 16'(b_flat[(k*4+j)*8 +: 8]);
        c_res[(i*4+j)*16 +: 16] = sum;
        a_ext[(i*4+j)*16 +: 16] = {8'd0, p.a[(i*4+j)*8 +: 8]};
      end
    end
    chk("product_eq_a", c_res, a_ext);
    handshake();

    // Backpressure: held in PRESENT with upstream valid
    p.a = rand128(); p.b = rand128();
    sb.push_back(p);
    load_beats(p.a, p.b, 0, 31, 1'b0);
    wait_present();
    in_valid = 1'b1; in_data = 8'hAA;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_a_stable", a_flat, last_p.a);
      chk("bp_b_stable", b_flat, last_p.b);
    end
    in_valid = 1'b0;
    handshake();

    // Gapped input
    for (int r = 0; r < 2; r++) begin
      p.a = rand128(); p.b = rand128();
      sb.push_back(p);
      load_beats(p.a, p.b, 0, 31, 1'b1);
      wait_present();
      handshake();
    end

    // Clear after 20 beats (in LOAD_B); beat offered during clear must be dropped
    p.a = rand128(); p.b = rand128();
    load_beats(p.a, p.b, 0, 19, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_pair_cnt", pair_cnt, exp_cnt);
    chk("clr_a_kept", a_flat, p.a);
    p.a = rand128(); p.b = rand128();
    sb.push_back(p);
    load_beats(p.a, p.b, 0, 31, 1'b0);
    wait_present();
    handshake();

    // Clear in PRESENT beats out_ready: pair not counted, data kept
    p.a = rand128(); p.b = rand128();
    sb.push_back(p);
    load_beats(p.a, p.b, 0, 31, 1'b0);
    wait_present();
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    chk("clrp_out_valid", out_valid, 0);
    chk("clrp_pair_cnt", pair_cnt, exp_cnt);
    chk("clrp_a_kept", a_flat, last_p.a);
    chk("clrp_b_kept", b_flat, last_p.b);

    // Asynchronous reset while presenting
    p.a = rand128(); p.b = rand128();
    sb.push_back(p);
    load_beats(p.a, p.b, 0, 31, 1'b0);
    wait_present();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_a_flat", a_flat, 0);
    chk("arst_b_flat", b_flat, 0);
    chk("arst_pair_cnt", pair_cnt, 0);
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Counter wrap over 256 deliveries
    for (int r = 0; r < 256; r++) begin
      p.a = rand128(); p.b = rand128();
      sb.push_back(p);
      load_beats(p.a, p.b, 0, 31, 1'b0);
      wait_present();
      handshake();
    end
    chk("wrap_to_zero", pair_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
